param_stream_loader: RTL and testbench

PARAM_STREAM_LOADER -- requirements
Module: param_stream_loader

---
 rtl/param_stream_loader.sv | 161 ++++++++++++++++
 tb/tb_param_stream_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_stream_loader.sv
// param_stream_loader: streams ROWS x COLS parameter words, row-major, into a register matrix
//   and serves registered random reads from it.
// Ports: clk, reset (async, active high); start/abort control the load;
//   load_valid/load_data/load_ready form the word stream; busy/done report load status;
//   rd_en/rd_row/rd_col -> rd_data/rd_valid one cycle later; cksum is the load checksum.
// Latency: an accepted word lands in storage on the next edge. A read returns one cycle after rd_en.
// Backpressure: load_ready is high only while loading. Words offered at any other time are dropped.
// Optional feature: define PARAM_LOADER_CKSUM_EN for a running XOR checksum. Otherwise cksum is tied to 0.
module param_stream_loader #(
    parameter  int DATA_W = 16,
    parameter  int ROWS   = 2,
    parameter  int COLS   = 4,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              busy,
    output logic              done,
    input  logic              rd_en,
    input  logic [RW-1:0]     rd_row,
    input  logic [CW-1:0]     rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] cksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    // Limits are one bit wider than the index so that non-power-of-two sizes compare correctly.
    localparam logic [RW:0]   ROWS_LIM = (RW + 1)'(ROWS);
    localparam logic [CW:0]   COLS_LIM = (CW + 1)'(COLS);

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DATA_W-1:0] mem_q [ROWS][COLS];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              accept;
    logic              rd_in_range;

    // FSM state and write pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD: begin
                // abort wins over a word presented in the same cycle; that word is dropped
                if (abort) begin
                    state_d = IDLE;
                end else if (load_valid) begin
                    accept = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_ready = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);

    // Storage: cleared by reset, written one word per accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            mem_q[row_q][col_q] <= load_data;
        end
    end

    // Registered read. The storage is sampled before this edge's write lands, so a
    // same-address read and write return the old word.
    assign rd_in_range = ({1'b0, rd_row} < ROWS_LIM) && ({1'b0, rd_col} < COLS_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_in_range ? mem_q[rd_row][rd_col] : '0;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

`ifdef PARAM_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    // Running XOR of the words accepted since the last start. The value is held after the load ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cksum_q <= '0;
        end else if (accept) begin
            cksum_q <= cksum_q ^ load_data;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_param_stream_loader.sv
`timescale 1ns/1ps
module tb_param_stream_loader;
    localparam int ROWS = 2;
    localparam int COLS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        reset, start, abort, load_valid, rd_en;
    logic [15:0] load_data;
    logic [0:0]  rd_row;
    logic [1:0]  rd_col;
    logic        load_ready, busy, done, rd_valid;
    logic [15:0] rd_data, cksum;

    param_stream_loader #(.DATA_W(16), .ROWS(2), .COLS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid), .cksum(cksum)
    );

    // 3x3 instance
    logic        b_reset, b_start, b_abort, b_load_valid, b_rd_en;
    logic [15:0] b_load_data;
    logic [1:0]  b_rd_row, b_rd_col;
    logic        b_load_ready, b_busy, b_done, b_rd_valid;
    logic [15:0] b_rd_data, b_cksum;

    param_stream_loader #(.DATA_W(16), .ROWS(3), .COLS(3)) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .abort(b_abort),
        .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
        .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_row(b_rd_row), .rd_col(b_rd_col),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .cksum(b_cksum)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: a phase, a count of accepted words and a word array.
    // The count maps to (count / COLS, count % COLS).
    int          m_phase = 0;   // 0 idle, 1 loading, 2 finished
    int          m_cnt   = 0;
    logic [15:0] m_mem [ROWS][COLS];
    logic [15:0] m_rd_data = '0;
    logic        m_rd_valid = 1'b0;
    logic [15:0] m_cksum = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_cnt = 0; m_rd_data = '0; m_rd_valid = 1'b0; m_cksum = '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) m_mem[r][c] = '0;
        end else begin
            m_rd_valid = rd_en;
            if (rd_en) begin
                if (int'(rd_row) < ROWS && int'(rd_col) < COLS) m_rd_data = m_mem[rd_row][rd_col];
                else m_rd_data = '0;
            end
            if (m_phase == 0) begin
                if (start) begin m_phase = 1; m_cnt = 0; m_cksum = '0; end
            end else if (m_phase == 1) begin
                if (abort) m_phase = 0;
                else if (load_valid) begin
                    m_mem[m_cnt / COLS][m_cnt % COLS] = load_data;
                    m_cksum = m_cksum ^ load_data;
                    m_cnt++;
                    if (m_cnt == ROWS * COLS) m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    function automatic logic [15:0] exp_cksum(input logic [15:0] v);
`ifdef PARAM_LOADER_CKSUM_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic cmp_model(input string tag);
        check({tag, ".load_ready"}, load_ready, m_phase == 1);
        check({tag, ".busy"},       busy,       m_phase == 1);
        check({tag, ".done"},       done,       m_phase == 2);
        check({tag, ".rd_valid"},   rd_valid,   m_rd_valid);
        check({tag, ".rd_data"},    rd_data,    m_rd_data);
        check({tag, ".cksum"},      cksum,      exp_cksum(m_cksum));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    task automatic drive(input logic s, input logic a, input logic v, input logic [15:0] d,
                         input logic re, input logic [0:0] r, input logic [1:0] c);
        start = s; abort = a; load_valid = v; load_data = d; rd_en = re; rd_row = r; rd_col = c;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 16'h0, 0, 1'b0, 2'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic b_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic s, a, v; logic [15:0] d; logic re; logic [0:0] r; logic [1:0] c;
        logic e_ready, e_done, e_rvalid; logic [15:0] e_rdata;
    } vec_t;
    vec_t vt[12];

    int ready_cnt, done_cnt, k, cyc, stalls, done_at;
    logic [15:0] first_word, w;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1; b_reset = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 1'b0, 2'd0);
        b_start = 0; b_abort = 0; b_load_valid = 0; b_load_data = '0; b_rd_en = 0; b_rd_row = '0; b_rd_col = '0;
        #1;
        check("rst.load_ready", load_ready, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.rd_valid", rd_valid, 0);
        check("rst.rd_data", rd_data, 0);
        check("rst.cksum", cksum, 0);
        @(posedge clk); #1;
        reset = 1'b0; b_reset = 1'b0;

        // ---------------- basic stream 1..8 (table) ----------------
        vt[0] = '{1, 0, 0, 16'h0, 0, 1'b0, 2'd0, 1, 0, 0, 16'h0};
        for (int i = 1; i <= 8; i++)
            vt[i] = '{0, 0, 1, 16'(i), 0, 1'b0, 2'd0, (i < 8), (i == 8), 0, 16'h0};
        vt[9]  = '{0, 0, 0, 16'h0, 1, 1'b0, 2'd0, 0, 0, 1, 16'h0001};
        vt[10] = '{0, 0, 0, 16'h0, 1, 1'b1, 2'd3, 0, 0, 1, 16'h0008};
        vt[11] = '{0, 0, 0, 16'h0, 0, 1'b0, 2'd0, 0, 0, 0, 16'h0008};
        ready_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].s, vt[i].a, vt[i].v, vt[i].d, vt[i].re, vt[i].r, vt[i].c);
            step("tab");
            check($sformatf("tab%0d.load_ready", i), load_ready, vt[i].e_ready);
            check($sformatf("tab%0d.done", i), done, vt[i].e_done);
            check($sformatf("tab%0d.rd_valid", i), rd_valid, vt[i].e_rvalid);
            check($sformatf("tab%0d.rd_data", i), rd_data, vt[i].e_rdata);
            if (load_ready) ready_cnt++;
            if (done) done_cnt++;
        end
        check("tab.ready_cycles", ready_cnt, 8);
        check("tab.done_pulses", done_cnt, 1);
        check("tab.cksum", cksum, exp_cksum(16'h0008));

        // ---------------- stalled stream ----------------
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 1'b0, 2'd0);
        step("stall");
        start = 0;
        k = 1; cyc = 0; stalls = 0; done_at = -1;
        while (cyc < 40 && done_at < 0) begin
            load_valid = (cyc % 2 == 0) && (k <= 8);
            load_data  = 16'(k);
            step("stall");
            cyc++;
            if (load_valid) k++; else stalls++;
            if (done) done_at = cyc;
        end
        load_valid = 0;
        check("stall.done_seen", done_at >= 0, 1);
        check("stall.done_lag", done_at, 8 + stalls);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                drive(0, 0, 0, 16'h0, 1, 1'(r), 2'(c));
                step("stall_rd");
                check($sformatf("stall.mem[%0d][%0d]", r, c), rd_data, r * COLS + c + 1);
            end

        // ---------------- abort with a 4th word ----------------
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 1'b0, 2'd0); step("abort");
        drive(0, 0, 1, 16'h000A, 0, 1'b0, 2'd0); step("abort");
        drive(0, 0, 1, 16'h000B, 0, 1'b0, 2'd0); step("abort");
        drive(0, 0, 1, 16'h000C, 0, 1'b0, 2'd0); step("abort");
        drive(0, 1, 1, 16'h000D, 0, 1'b0, 2'd0); step("abort");
        check("abort.load_ready", load_ready, 0);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        drive(0, 0, 0, 16'h0, 1, 1'b0, 2'd2); step("abort");
        check("abort.mem02", rd_data, 16'h000C);
        check("abort.done_later", done, 0);
        drive(0, 0, 0, 16'h0, 1, 1'b0, 2'd3); step("abort");
        check("abort.mem03", rd_data, 16'h0000);
        // abort presented in IDLE together with start must not block the start
        drive(1, 1, 0, 16'h0, 0, 1'b0, 2'd0); step("abort_idle");
        check("abort_idle.load_ready", load_ready, 1);
        drive(0, 1, 0, 16'h0, 0, 1'b0, 2'd0); step("abort");

        // ---------------- read-before-write ----------------
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 1'b0, 2'd0); step("rbw");
        drive(0, 0, 1, 16'h0000, 0, 1'b0, 2'd0); step("rbw");
        drive(0, 0, 1, 16'h0011, 0, 1'b0, 2'd0); step("rbw");
        drive(0, 1, 0, 16'h0, 0, 1'b0, 2'd0); step("rbw");
        drive(1, 0, 0, 16'h0, 0, 1'b0, 2'd0); step("rbw");
        drive(0, 0, 1, 16'h0022, 0, 1'b0, 2'd0); step("rbw");
        drive(0, 0, 1, 16'h0055, 1, 1'b0, 2'd1); step("rbw");
        check("rbw.old_value", rd_data, 16'h0011);
        check("rbw.old_valid", rd_valid, 1);
        drive(0, 0, 0, 16'h0, 1, 1'b0, 2'd1); step("rbw");
        check("rbw.new_value", rd_data, 16'h0055);
        drive(0, 1, 0, 16'h0, 0, 1'b0, 2'd0); step("rbw");

        // ---------------- reset in mid-load ----------------
        do_reset();
        drive(1, 0, 0, 16'h0, 0, 1'b0, 2'd0); step("mrst");
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 1, 16'h0100 + 16'(i), (i == 2), 1'b0, 2'd0);
            step("mrst");
        end
        check("mrst.pre_rd_data", rd_data, 16'h0101);
        check("mrst.pre_busy", busy, 1);
        drive(0, 0, 0, 16'h0, 0, 1'b0, 2'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mrst.load_ready", load_ready, 0);
        check("mrst.busy", busy, 0);
        check("mrst.done", done, 0);
        check("mrst.rd_valid", rd_valid, 0);
        check("mrst.rd_data", rd_data, 0);
        check("mrst.cksum", cksum, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1, 0, 0, 16'h0, 0, 1'b0, 2'd0); step("mrst");
        first_word = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
            w = (i == 0) ? first_word : 16'($urandom);
            drive(0, 0, 1, w, 0, 1'b0, 2'd0);
            step("mrst");
        end
        check("mrst.done", done, 1);
        drive(0, 0, 0, 16'h0, 1, 1'b0, 2'd0); step("mrst");
        check("mrst.first_word", rd_data, first_word);

        // ---------------- randomized run against the model ----------------
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 8) == 0, ($urandom % 24) == 0, ($urandom % 4) != 0,
                  16'($urandom), $urandom % 2, 1'($urandom), 2'($urandom));
            step("rand");
        end
        drive(0, 0, 0, 16'h0, 0, 1'b0, 2'd0);

        // ---------------- 3x3 instance ----------------
        b_start = 1; b_step(); b_start = 0;
        check("b.load_ready", b_load_ready, 1);
        done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            b_load_valid = 1; b_load_data = 16'h0100 + 16'(i);
            b_step();
            if (b_done) done_cnt++;
            check($sformatf("b.done_after%0d", i), b_done, i == 8);
        end
        b_load_valid = 0;
        b_step();
        check("b.done_pulses", done_cnt, 1);
        check("b.idle_ready", b_load_ready, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                b_rd_en = 1; b_rd_row = 2'(r); b_rd_col = 2'(c);
                b_step();
                check($sformatf("b.mem[%0d][%0d]", r, c), b_rd_data, 16'h0100 + 16'(r * 3 + c));
            end
        b_rd_row = 2'd3; b_rd_col = 2'd0; b_step();
        check("b.oor_row_data", b_rd_data, 0);
        check("b.oor_row_valid", b_rd_valid, 1);
        b_rd_row = 2'd1; b_rd_col = 2'd3; b_step();
        check("b.oor_col_data", b_rd_data, 0);
        check("b.oor_col_valid", b_rd_valid, 1);
        b_rd_en = 0; b_step();
        check("b.rd_valid_low", b_rd_valid, 0);
        check("b.rd_data_hold", b_rd_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
